// File: rtl/led_sequencer_if.sv
// Switch/mode/colour controls and the three LED banks of led_sequencer.
// The board top (or bench) owns the master side; led_sequencer takes the slave side.
interface led_sequencer_if #(
    parameter int NB_LED = 4
);
    logic [3:0]        i_sw;
    logic              i_mode;
    logic [1:0]        i_color;
    logic [NB_LED-1:0] o_led;
    logic [NB_LED-1:0] o_led_g;
    logic [NB_LED-1:0] o_led_b;
    logic              o_valid;

    modport master (
        output i_sw,
        output i_mode,
        output i_color,
        input  o_led,
        input  o_led_g,
        input  o_led_b,
        input  o_valid
    );

    modport slave (
        input  i_sw,
        input  i_mode,
        input  i_color,
        output o_led,
        output o_led_g,
        output o_led_b,
        output o_valid
    );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: switch-selectable prescaler steps a rotating one-hot
// or flashing pattern, routed to the red, green and/or blue LED bank.
module led_sequencer #(
    parameter int NB_LED   = 4,
    parameter int NB_COUNT = 32,
    parameter int R0       = 25_000_000,
    parameter int R1       = 12_500_000,
    parameter int R2       = 6_250_000,
    parameter int R3       = 3_125_000
) (
    input  logic          clock,
    input  logic          i_reset,
    led_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        BANK_RED   = 2'd0,
        BANK_GREEN = 2'd1,
        BANK_BLUE  = 2'd2,
        BANK_ALL   = 2'd3
    } bank_e;

    typedef enum logic {
        MODE_SHIFT = 1'b0,
        MODE_FLASH = 1'b1
    } mode_e;

    localparam logic [NB_COUNT-1:0] LIM0     = NB_COUNT'(R0 - 1);
    localparam logic [NB_COUNT-1:0] LIM1     = NB_COUNT'(R1 - 1);
    localparam logic [NB_COUNT-1:0] LIM2     = NB_COUNT'(R2 - 1);
    localparam logic [NB_COUNT-1:0] LIM3     = NB_COUNT'(R3 - 1);
    localparam logic [NB_LED-1:0]   PAT_INIT = NB_LED'(1);

    logic [NB_COUNT-1:0] count_q, count_d;
    logic [NB_LED-1:0]   pattern_q, pattern_d;
    logic [NB_LED-1:0]   led_r_q, led_r_d;
    logic [NB_LED-1:0]   led_g_q, led_g_d;
    logic [NB_LED-1:0]   led_b_q, led_b_d;
    logic                valid_q, valid_d;

    logic [NB_COUNT-1:0] limit_m1;
    logic                enable;
    logic                step;
    logic                one_hot;
    bank_e               bank_sel;
    mode_e               mode_sel;

    always_comb begin
        enable   = bus.i_sw[0];
        bank_sel = bank_e'(bus.i_color);
        mode_sel = mode_e'(bus.i_mode);

        unique case (bus.i_sw[2:1])
            2'd0:    limit_m1 = LIM0;
            2'd1:    limit_m1 = LIM1;
            2'd2:    limit_m1 = LIM2;
            default: limit_m1 = LIM3;
        endcase

        // >= rather than == so a switch to a faster rate never wraps the counter
        step = enable && (count_q >= limit_m1);

        count_d = count_q + NB_COUNT'(1);
        if (!enable || step) begin
            count_d = '0;
        end
    end

    always_comb begin
        one_hot   = (pattern_q != '0) && ((pattern_q & (pattern_q - NB_LED'(1))) == '0);
        pattern_d = pattern_q;
        if (step) begin
            if (mode_sel == MODE_FLASH) begin
                pattern_d = (pattern_q == '0) ? '1 : '0;
            end else if (!one_hot) begin
                pattern_d = PAT_INIT;
            end else if (bus.i_sw[3]) begin
                pattern_d = {pattern_q[0], pattern_q[NB_LED-1:1]};
            end else begin
                pattern_d = {pattern_q[NB_LED-2:0], pattern_q[NB_LED-1]};
            end
        end
        valid_d = step;
    end

    always_comb begin
        led_r_d = '0;
        led_g_d = '0;
        led_b_d = '0;
        unique case (bank_sel)
            BANK_RED:   led_r_d = pattern_q;
            BANK_GREEN: led_g_d = pattern_q;
            BANK_BLUE:  led_b_d = pattern_q;
            BANK_ALL: begin
                led_r_d = pattern_q;
                led_g_d = pattern_q;
                led_b_d = pattern_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q   <= '0;
            pattern_q <= PAT_INIT;
            led_r_q   <= '0;
            led_g_q   <= '0;
            led_b_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            pattern_q <= pattern_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            led_b_q   <= led_b_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.o_led   = led_r_q;
    assign bus.o_led_g = led_g_q;
    assign bus.o_led_b = led_b_q;
    assign bus.o_valid = valid_q;

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the board top level. It replaces the fixed `count` + `shiftreg` pair with a single block. A prescaler with four switch-selectable rates produces a step pulse. On each step, an NB_LED-bit pattern register rotates (either direction) or flashes. The pattern is routed to one or all of the red, green and blue LED banks.

## Interface
- NB_LED, 4, pattern and LED bank width (≥2)
- NB_COUNT, 32, prescaler counter width
- R0, 25_000_000, step period in clocks for rate 0 (≥2)
- R1, 12_500_000, step period for rate 1 (≥2)
- R2, 6_250_000, step period for rate 2 (≥2)
- R3, 3_125_000, step period for rate 3 (≥2); all Rn < 2**NB_COUNT
- clock  in  1  single system clock; all state updates on the rising edge
- i_reset  in  1  reset, asynchronous assert, active-low (0 = reset)
- i_sw  in  4  [0] enable, [2:1] rate select (R0..R3), [3] direction (0 = rotate left/up, 1 = rotate right/down)
- i_mode  in  1  0 = shift (rotate one-hot), 1 = flash (all-on/all-off)
- i_color  in  2  bank select: 0 = o_led (red), 1 = o_led_g, 2 = o_led_b, 3 = all three
- o_led  out  NB_LED  red bank, registered
- o_led_g  out  NB_LED  green bank, registered
- o_led_b  out  NB_LED  blue bank, registered
- o_valid  out  1  one-cycle pulse, high in the cycle the pattern register holds a new value

## Operation
- Reset (i_reset=0, async): counter=0, pattern=NB_LED'b1, o_led/o_led_g/o_led_b=0, o_valid=0.
- Prescaler: limit L = Rn selected by i_sw[2:1], sampled every cycle.
  - Enable=1: if counter ≥ L-1, then step=1 and counter←0; else counter←counter+1.
  - Using ≥ ensures that switching to a faster rate mid-count steps immediately, with no wrap through 2**NB_COUNT.
  - Enable=0: counter←0, step=0; pattern holds; outputs keep following pattern/i_color.
- Pattern update on step:
  - Shift mode, pattern one-hot: rotate left (MSB wraps to bit 0) if i_sw[3]=0; rotate right (bit 0 wraps to MSB) if i_sw[3]=1.
  - Shift mode, pattern not one-hot (e.g. after flash): pattern←NB_LED'b1, no rotate in that step.
  - Flash mode: pattern←all-ones if pattern==0, else pattern←0.
  - Mode and direction are sampled only on step cycles. Changes take effect at the next step.
- o_valid←step (registered). It is high for exactly the one cycle after the pattern register edge.
- Output routing (registered, every cycle):
  - Selected bank(s)←pattern.
  - Unselected banks←0.
  - i_color=3 drives all three banks with pattern.

## Timing
- Step cadence: exactly L clocks between pattern updates at constant rate with enable held high.
- Enable 0→1 at edge E: counter counts 0..L-1, so the first step is asserted in cycle E+L-1 (counter==L-1).
- Pattern updates at the edge ending the step cycle. o_valid is high during the following cycle. The LED banks show the new pattern one edge after that (2-edge latency from step to LEDs).
- i_color change: banks reflect the new routing after 1 edge. There is no glitch cycle with two banks lit unless i_color=3.
- Reset mid-operation: all state is cleared asynchronously. After release, the first rising edge loads outputs from pattern=1 (with current i_color), and the counter restarts from 0.
- Rate change: takes effect in the same cycle. If counter ≥ new L-1, a step occurs in that cycle.
- Enable drop on a step cycle: no step is taken, and the counter clears.

## Test plan
- Bench overrides R0=4, R1=8, R2=16, R3=32, NB_LED=4.
- Reset, then i_sw=4'b0001, i_mode=0, i_color=0 -> o_led sequence 0001,0010,0100,1000,0001 with exactly 4 clocks between changes; o_valid pulses once per change; o_led_g=o_led_b=0.
- Same, i_sw[3]=1 -> o_led sequence 0001,1000,0100,0010,0001; wrap from bit 0 to MSB.
- i_mode=1, rate 1 -> o_led toggles 1111/0000 every 8 clocks. Then i_mode=0 -> next step loads 0001, and the following step gives 0010.
- Rate 3 running, counter≈20, switch i_sw[2:1]=0 -> step in that same cycle; subsequent steps every 4 clocks.
- i_color cycles 0,1,2,3 with pattern 0100 -> after 1 edge each: red / green / blue only / all three banks = 0100; others 0.
- Assert i_reset=0 mid-count for 1 cycle, asynchronously between edges -> outputs 0 immediately. After release: o_led=0001 at the first edge; next change 4 clocks later.
